// File: rtl/edge_evt_pkg.sv
// Shared types for edge_event_arbiter: event payload, output-stage state, limits.
// The timestamp field is only stored when EDGE_EVT_TIMESTAMP_EN is defined.
package edge_evt_pkg;

    localparam int N_CH_MAX = 16;
    localparam int EVT_TS_W = 16;

    typedef struct packed {
        logic                rising;
        logic [EVT_TS_W-1:0] ts;
    } evt_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } out_state_t;

endpackage

// File: rtl/edge_detector.sv
// Registered single-line edge detector; the first edge after reset only arms
// the history register, so a line held high through reset gives no event.
module edge_detector (
    input  logic clk,
    input  logic rst,
    input  logic i_in,
    output logic o_pulse,
    output logic o_rising
);

    logic r_armed;
    logic r_hist;
    logic r_pulse;
    logic r_rising;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_armed  <= 1'b0;
            r_hist   <= 1'b0;
            r_pulse  <= 1'b0;
            r_rising <= 1'b0;
        end else begin
            r_armed  <= 1'b1;
            r_hist   <= i_in;
            r_pulse  <= r_armed && (i_in != r_hist);
            r_rising <= i_in;
        end
    end

    assign o_pulse  = r_pulse;
    assign o_rising = r_rising;

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel edge events, one-deep pending slots, round-robin drain to a valid/ready port.
// Optional capture timestamps with EDGE_EVT_TIMESTAMP_EN (TS_W must equal edge_evt_pkg::EVT_TS_W).
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int N_CH  = 4,
`ifdef EDGE_EVT_TIMESTAMP_EN
    parameter int TS_W  = EVT_TS_W,
`endif
    parameter int OVF_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          in,
    input  logic                     enable,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(N_CH)-1:0]  out_ch,
    output logic                     out_rising,
`ifdef EDGE_EVT_TIMESTAMP_EN
    output logic [TS_W-1:0]          out_ts,
`endif
    output logic [OVF_W-1:0]         overflow_count
);

    localparam int CH_W   = $clog2(N_CH);
    localparam int DROP_W = $clog2(N_CH_MAX + 1);
    localparam int SUM_W  = OVF_W + DROP_W;
    localparam logic [CH_W-1:0]  RR_RESET = CH_W'(N_CH - 1);
    localparam logic [OVF_W-1:0] OVF_MAX  = '1;

`ifdef EDGE_EVT_TIMESTAMP_EN
    typedef evt_t slot_t;
`else
    typedef struct packed { logic rising; } slot_t;
`endif

    logic [N_CH-1:0]   w_pulse;
    logic [N_CH-1:0]   w_pulse_rising;
    slot_t             r_slot [N_CH];
    logic [N_CH-1:0]   r_slot_valid;
    slot_t             r_out;
    logic [CH_W-1:0]   r_out_ch;
    logic [CH_W-1:0]   r_rr;
    logic [OVF_W-1:0]  r_ovf;
    out_state_t        r_state;
    out_state_t        w_state_next;
    logic              w_found;
    logic              w_load;
    logic [CH_W-1:0]   w_grant;
    logic [N_CH-1:0]   w_drain;
    logic [N_CH-1:0]   w_drop;
    logic [DROP_W-1:0] w_drop_cnt;
    logic [SUM_W-1:0]  w_ovf_sum;
    logic [OVF_W-1:0]  w_ovf_next;
`ifdef EDGE_EVT_TIMESTAMP_EN
    logic [TS_W-1:0]   r_ts;
`endif

    for (genvar g = 0; g < N_CH; g++) begin : g_det
        edge_detector u_det (
            .clk      (clk),
            .rst      (rst),
            .i_in     (in[g]),
            .o_pulse  (w_pulse[g]),
            .o_rising (w_pulse_rising[g])
        );
    end

    // First valid slot after ptr, wrapping; MSB of the result flags a hit.
    function automatic logic [CH_W:0] rr_grant(input logic [N_CH-1:0] valid,
                                               input logic [CH_W-1:0] ptr);
        logic [CH_W:0]   res;
        logic [CH_W-1:0] sel;
        res = '0;
        for (int k = N_CH; k >= 1; k--) begin
            sel = CH_W'((int'(ptr) + k) % N_CH);
            if (valid[sel]) res = {1'b1, sel};
        end
        return res;
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_drain      = '0;
        w_drop       = '0;
        w_drop_cnt   = '0;
        {w_found, w_grant} = rr_grant(r_slot_valid, r_rr);
        w_load = ((r_state == IDLE) || out_ready) && w_found;
        if (w_load)                            w_state_next = PRESENT;
        else if (r_state == PRESENT && out_ready) w_state_next = IDLE;
        for (int i = 0; i < N_CH; i++) begin
            w_drain[i] = w_load && (w_grant == CH_W'(i));
            w_drop[i]  = enable && w_pulse[i] && r_slot_valid[i] && !w_drain[i];
            w_drop_cnt = w_drop_cnt + DROP_W'(w_drop[i]);
        end
        w_ovf_sum  = {{DROP_W{1'b0}}, r_ovf} + {{OVF_W{1'b0}}, w_drop_cnt};
        w_ovf_next = (w_ovf_sum > {{DROP_W{1'b0}}, OVF_MAX}) ? OVF_MAX : w_ovf_sum[OVF_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    // NOTE: slot payloads are reset along with the valid bits so drained outputs are never X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot_valid <= '0;
            r_slot       <= '{default: '0};
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (enable && w_pulse[i] && (!r_slot_valid[i] || w_drain[i])) begin
                    r_slot_valid[i]  <= 1'b1;
                    r_slot[i].rising <= w_pulse_rising[i];
`ifdef EDGE_EVT_TIMESTAMP_EN
                    r_slot[i].ts     <= r_ts;
`endif
                end else if (w_drain[i]) begin
                    r_slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out    <= '0;
            r_out_ch <= '0;
            r_rr     <= RR_RESET;
            r_ovf    <= '0;
        end else begin
            if (w_load) begin
                r_out    <= r_slot[w_grant];
                r_out_ch <= w_grant;
                r_rr     <= w_grant;
            end
            r_ovf <= w_ovf_next;
        end
    end

`ifdef EDGE_EVT_TIMESTAMP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_ts <= '0;
        else      r_ts <= r_ts + TS_W'(1);
    end

    assign out_ts = r_out.ts;
`endif

    assign out_valid      = (r_state == PRESENT);
    assign out_ch         = r_out_ch;
    assign out_rising     = r_out.rising;
    assign overflow_count = r_ovf;

endmodule
